fp_operand_align: RTL

Multi-cycle operand pre-alignment stage for the single-precision floating-point add/subtract datapath. It accepts two IEEE-754 operands, determines which has the larger magnitude (`cmp_out`), and unpacks both mantissas. It then right-shifts the smaller mantissa one bit per cycle, with guard/round/sticky bits, until the exponents match. Its outputs feed the mantissa adder and, through `cmp_out` and the captured operand signs, the downstream sign-determination logic.

---
 rtl/fp_operand_align.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fp_operand_align.sv
// fp_operand_align
//
// Operand pre-alignment stage for the single-precision add/subtract path.
// Accepts two IEEE-754 operands, picks the larger magnitude, unpacks both
// mantissas and right-shifts the smaller one (one bit per cycle, with a
// sticky bit) until both operands share the larger exponent.
//
// Ports:
//   CLK             clock, rising edge
//   nRST            synchronous active-low reset
//   in_valid        operands valid (accepted only in IDLE)
//   in_ready        high only while IDLE
//   floating_point1 operand 1 (minuend)
//   floating_point2 operand 2 (subtrahend)
//   out_valid       aligned result valid (DONE state)
//   out_ready       consumer accepts the result
//   cmp_out         1 iff |fp1| < |fp2|
//   sign1, sign2    captured sign bits of fp1 / fp2
//   exp_max         effective exponent of the larger operand
//   frac_large      {hidden, frac, G, R, S} of the larger operand
//   frac_small      aligned {hidden, frac, G, R, S} of the smaller operand

module fp_operand_align #(
  parameter int SHIFT_LIMIT = 27
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] floating_point1,
  input  logic [31:0] floating_point2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        cmp_out,
  output logic        sign1,
  output logic        sign2,
  output logic [7:0]  exp_max,
  output logic [26:0] frac_large,
  output logic [26:0] frac_small
);

  typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

  // Widened so a limit above 255 simply never triggers saturation.
  localparam logic [8:0] LIMIT = 9'(SHIFT_LIMIT);

  state_t      state;
  state_t      state_next;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [7:0]  count;

  logic        hid1, hid2;
  logic [7:0]  eff1, eff2;
  logic [26:0] mant1, mant2;
  logic        op1_lt;
  logic [7:0]  eff_large, eff_small;
  logic [26:0] mant_large, mant_small;
  logic [7:0]  diff;
  logic        saturate;

  // Denormals have no hidden bit but share the exponent-1 scale, so both the
  // comparison and the shift distance use the effective exponent.
  always_comb begin
    hid1       = |op1[30:23];
    hid2       = |op2[30:23];
    eff1       = hid1 ? op1[30:23] : 8'd1;
    eff2       = hid2 ? op2[30:23] : 8'd1;
    mant1      = {hid1, op1[22:0], 3'b000};
    mant2      = {hid2, op2[22:0], 3'b000};
    op1_lt     = {eff1, hid1, op1[22:0]} < {eff2, hid2, op2[22:0]};
    eff_large  = op1_lt ? eff2 : eff1;
    eff_small  = op1_lt ? eff1 : eff2;
    mant_large = op1_lt ? mant2 : mant1;
    mant_small = op1_lt ? mant1 : mant2;
    diff       = eff_large - eff_small;
    saturate   = {1'b0, diff} >= LIMIT;
  end

  // Next-state logic. The shift counter is loaded with d >= 1 on entry to
  // SHIFT, so reaching 1 means the current shift is the last one.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CMP;
      CMP:     state_next = (diff == 8'd0 || saturate) ? DONE : SHIFT;
      SHIFT:   if (count == 8'd1) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Datapath registers. Results are written once in CMP; only frac_small
  // moves afterwards, and only while in SHIFT.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      op1        <= '0;
      op2        <= '0;
      count      <= '0;
      cmp_out    <= 1'b0;
      sign1      <= 1'b0;
      sign2      <= 1'b0;
      exp_max    <= '0;
      frac_large <= '0;
      frac_small <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op1 <= floating_point1;
            op2 <= floating_point2;
          end
        end
        CMP: begin
          cmp_out    <= op1_lt;
          sign1      <= op1[31];
          sign2      <= op2[31];
          exp_max    <= eff_large;
          frac_large <= mant_large;
          // A distance this large would shift everything into sticky anyway.
          frac_small <= saturate ? {26'b0, |mant_small} : mant_small;
          count      <= diff;
        end
        SHIFT: begin
          // Bit 0 accumulates everything shifted past the round position.
          frac_small <= {1'b0, frac_small[26:2], frac_small[1] | frac_small[0]};
          count      <= count - 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
